// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy sprite renderer: scheduler states,
// screen geometry, colour depth and default sprite parameters.
package snoopy_pkg;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_LATCH = 3'd3,
        S_DRAW  = 3'd4
    } draw_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam int SPRITE_W_DEF  = 16;
    localparam int SPRITE_H_DEF  = 16;
    localparam int FRAME_DIV_DEF = 833334;
    localparam int X_MAX_DEF     = SCREEN_W - SPRITE_W_DEF;
    localparam int Y_MAX_DEF     = SCREEN_H - SPRITE_H_DEF;
    localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF = 3'b000;

    // Unsigned saturation; an 8'hFF wrap from x=0 therefore pins to the limit.
    function automatic logic [7:0] clamp_u8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running divider: emits a one-cycle tick on the last count of each period.
module frame_tick_gen #(
    parameter int DIV = 833334
) (
    input  logic i_clock,
    input  logic i_resetn,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/snoopy_draw_controller.sv
// Per-frame erase / move / latch / draw scheduler for the Snoopy sprite;
// sole driver of the VGA adapter's plot interface.
module snoopy_draw_controller
    import snoopy_pkg::*;
#(
    parameter int SPRITE_W  = SPRITE_W_DEF,
    parameter int SPRITE_H  = SPRITE_H_DEF,
    parameter int FRAME_DIV = FRAME_DIV_DEF,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
    input  logic                                    clock,
    input  logic                                    resetn,
    input  logic [7:0]                              snoopy_x,
    input  logic [6:0]                              snoopy_y,
    input  logic [2:0]                              rom_colour,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]    rom_addr,
    output logic                                    move_en,
    output logic [7:0]                              vga_x,
    output logic [6:0]                              vga_y,
    output logic [2:0]                              vga_colour,
    output logic                                    plot,
    output logic                                    busy
);

    localparam int PIX_N = SPRITE_W * SPRITE_H;
    localparam int CNT_W = $clog2(PIX_N);
    localparam int XB    = $clog2(SPRITE_W);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_N - 1);

    draw_state_t      r_state;
    draw_state_t      w_state_next;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] w_pix_cnt_next;
    logic [7:0]       r_cur_x;
    logic [6:0]       r_cur_y;
    logic             r_tick_pending;
    logic             w_tick;
    logic             w_consume;
    logic             w_latch;

    logic             r_plot;
    logic             r_draw;
    logic [7:0]       r_px;
    logic [6:0]       r_py;

    frame_tick_gen #(
        .DIV (FRAME_DIV)
    ) u_tick (
        .i_clock  (clock),
        .i_resetn (resetn),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_pix_cnt_next = r_pix_cnt;
        w_consume      = 1'b0;
        w_latch        = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (r_tick_pending) begin
                    w_consume      = 1'b1;
                    w_pix_cnt_next = '0;
                    w_state_next   = S_ERASE;
                end
            end
            S_ERASE: begin
                if (r_pix_cnt == LAST_PIX) begin
                    w_pix_cnt_next = '0;
                    w_state_next   = S_MOVE;
                end else begin
                    w_pix_cnt_next = r_pix_cnt + CNT_W'(1);
                end
            end
            S_MOVE: begin
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_latch        = 1'b1;
                w_pix_cnt_next = '0;
                w_state_next   = S_DRAW;
            end
            S_DRAW: begin
                if (r_pix_cnt == LAST_PIX) begin
                    w_pix_cnt_next = '0;
                    w_state_next   = S_WAIT;
                end else begin
                    w_pix_cnt_next = r_pix_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state        <= S_WAIT;
            r_pix_cnt      <= '0;
            r_cur_x        <= '0;
            r_cur_y        <= '0;
            r_tick_pending <= 1'b0;
            r_plot         <= 1'b0;
            r_draw         <= 1'b0;
            r_px           <= '0;
            r_py           <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pix_cnt <= w_pix_cnt_next;
            // Consumption wins, so a tick landing on a set flag is simply lost.
            if (w_consume) begin
                r_tick_pending <= 1'b0;
            end else if (w_tick) begin
                r_tick_pending <= 1'b1;
            end
            if (w_latch) begin
                r_cur_x <= clamp_u8(snoopy_x, 8'(X_MAX));
                r_cur_y <= 7'(clamp_u8({1'b0, snoopy_y}, 8'(Y_MAX)));
            end
            r_plot <= (r_state == S_ERASE) || (r_state == S_DRAW);
            r_draw <= (r_state == S_DRAW);
            r_px   <= r_cur_x + 8'(r_pix_cnt[XB-1:0]);
            r_py   <= r_cur_y + 7'(r_pix_cnt[CNT_W-1:XB]);
        end
    end

    // ROM read is registered, so its data lines up with the pipelined coordinates.
    assign rom_addr   = (r_state == S_DRAW) ? r_pix_cnt : '0;
    assign vga_colour = r_plot ? (r_draw ? rom_colour : BG_COLOUR) : 3'b000;
    assign vga_x      = r_px;
    assign vga_y      = r_py;
    assign plot       = r_plot;
    assign move_en    = (r_state == S_MOVE);
    assign busy       = (r_state != S_WAIT);

endmodule
